// File: rtl/multicycle_control_if.sv
// Connects the multicycle control unit to its datapath: decode fields and
// status flags go in, datapath strobes and mux selects come out.
interface multicycle_control_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;

    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
    logic       trap;
    logic [3:0] state;

    // Datapath side: supplies instruction fields and flags, consumes controls.
    modport master (
        output op, funct3, funct7b5, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, reg_write,
        input  result_src, alu_src_a, alu_src_b, imm_src, alu_control, trap, state
    );

    // Control unit side.
    modport slave (
        input  op, funct3, funct7b5, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, reg_write,
        output result_src, alu_src_a, alu_src_b, imm_src, alu_control, trap, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Main FSM for a multicycle RV32I subset (lw/sw/R/I/jal/beq) with a sticky
// illegal-opcode trap; strobes are combinational from state and inputs.
module multicycle_control (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.slave  bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t     state_q;
    state_t     state_d;

    logic       pc_update;
    logic       branch;
    logic       ir_write_c;
    logic       reg_write_c;
    logic       mem_write_c;
    logic       adr_src_c;
    logic [1:0] result_src_c;
    logic [1:0] alu_src_a_c;
    logic [1:0] alu_src_b_c;
    logic [1:0] alu_op;
    logic       trap_c;
    logic [2:0] alu_control_c;
    logic [1:0] imm_src_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_update    = 1'b0;
        branch       = 1'b0;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        mem_write_c  = 1'b0;
        adr_src_c    = 1'b0;
        result_src_c = 2'b00;
        alu_src_a_c  = 2'b00;
        alu_src_b_c  = 2'b00;
        alu_op       = 2'b00;
        trap_c       = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b_c  = 2'b10;
                result_src_c = 2'b10;
                ir_write_c   = bus.mem_ready;
                pc_update    = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b01;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
                state_d     = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src_c = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src_c = 2'b01;
                reg_write_c  = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src_c   = 1'b1;
                mem_write_c = 1'b1;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a_c = 2'b10;
                alu_op      = 2'b10;
                state_d     = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
                alu_op      = 2'b10;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b10;
                pc_update   = 1'b1;
                state_d     = S_ALUWB;
            end
            S_BEQ: begin
                alu_src_a_c = 2'b10;
                alu_op      = 2'b01;
                branch      = 1'b1;
                state_d     = S_FETCH;
            end
            // TRAP and the unused codes 12-15 park here until reset.
            default: begin
                trap_c  = 1'b1;
                state_d = S_TRAP;
            end
        endcase
    end

    always_comb begin
        alu_control_c = 3'b000;
        case (alu_op)
            2'b01: alu_control_c = 3'b001;
            2'b10: begin
                case (bus.funct3)
                    3'b000:  alu_control_c = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alu_control_c = 3'b101;
                    3'b110:  alu_control_c = 3'b011;
                    3'b111:  alu_control_c = 3'b010;
                    default: alu_control_c = 3'b000;
                endcase
            end
            default: alu_control_c = 3'b000;
        endcase
    end

    always_comb begin
        imm_src_c = 2'b00;
        case (bus.op)
            OP_SW:   imm_src_c = 2'b01;
            OP_BEQ:  imm_src_c = 2'b10;
            OP_JAL:  imm_src_c = 2'b11;
            default: imm_src_c = 2'b00;
        endcase
    end

    // State is already FETCH while rst_n is low, but FETCH raises ir/pc writes
    // on mem_ready, so every write strobe is also masked by rst_n directly.
    assign bus.pc_write    = rst_n & (pc_update | (branch & bus.zero));
    assign bus.ir_write    = rst_n & ir_write_c;
    assign bus.reg_write   = rst_n & reg_write_c;
    assign bus.mem_write   = rst_n & mem_write_c;
    assign bus.adr_src     = adr_src_c;
    assign bus.result_src  = result_src_c;
    assign bus.alu_src_a   = alu_src_a_c;
    assign bus.alu_src_b   = alu_src_b_c;
    assign bus.imm_src     = imm_src_c;
    assign bus.alu_control = alu_control_c;
    assign bus.trap        = trap_c;
    assign bus.state       = state_q;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous active-low reset.
REQ-003 op  input  7  instruction[6:0] from instruction register.
REQ-004 funct3  input  3  instruction[14:12].
REQ-005 funct7b5  input  1  instruction[30].
REQ-006 zero  input  1  ALU zero flag, current cycle.
REQ-007 mem_ready  input  1  memory completes current access this cycle.
REQ-008 pc_write, adr_src, mem_write, ir_write, reg_write  output  1 each  datapath strobes/selects.
REQ-009 result_src, alu_src_a, alu_src_b, imm_src  output  2 each  datapath mux selects.
REQ-010 alu_control  output  3  ALU operation.
REQ-011 trap  output  1  illegal opcode seen; sticky.
REQ-012 state  output  4  current FSM state code, for debug.

Function
REQ-013 Encodings: alu_src_a 00=PC, 01=OldPC, 10=RD1; alu_src_b 00=RD2, 01=ImmExt, 10=4; result_src 00=ALUOut, 01=Data, 10=ALUResult; adr_src 0=PC, 1=Result; imm_src 00=I, 01=S, 10=B, 11=J.
REQ-014 States/codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, ALUWB 7, EXECI 8, JAL 9, BEQ 10, TRAP 11; 12-15 unreachable, decode as TRAP.
REQ-015 Default every cycle: all 1-bit outputs 0, all selects 00, alu_op 00; state-specific values below override.
REQ-016 FETCH: adr_src 0, alu_src_a 00, alu_src_b 10, alu_op 00, result_src 10; ir_write=mem_ready, pc_update=mem_ready; stay while mem_ready=0, else DECODE.
REQ-017 DECODE: alu_src_a 01, alu_src_b 01, alu_op 00; next by op: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BEQ, 1101111->JAL, other->TRAP.
REQ-018 MEMADR: alu_src_a 10, alu_src_b 01, alu_op 00; next MEMREAD if op=0000011, else MEMWRITE.
REQ-019 MEMREAD: adr_src 1, result_src 00; stay until mem_ready=1, then MEMWB.
REQ-020 MEMWB: result_src 01, reg_write 1; next FETCH.
REQ-021 MEMWRITE: adr_src 1, result_src 00, mem_write 1 held until mem_ready=1 (inclusive); then FETCH.
REQ-022 EXECR: alu_src_a 10, alu_src_b 00, alu_op 10; next ALUWB. EXECI: same but alu_src_b 01; next ALUWB.
REQ-023 ALUWB: result_src 00, reg_write 1; next FETCH.
REQ-024 JAL: alu_src_a 01, alu_src_b 10, alu_op 00, result_src 00, pc_update 1; next ALUWB.
REQ-025 BEQ: alu_src_a 10, alu_src_b 00, alu_op 01, result_src 00, branch 1; next FETCH.
REQ-026 pc_write = pc_update | (branch & zero), combinational.
REQ-027 imm_src combinational from op: 0100011->01, 1100011->10, 1101111->11, else 00.
REQ-028 alu_control: alu_op 00->000 (add); 01->001 (sub); 10 by funct3: 000->001 if op[5]&funct7b5 else 000; 010->101 (slt); 110->011 (or); 111->010 (and); other funct3->000.
REQ-029 TRAP: all write strobes 0, trap 1, remains until reset.
REQ-030 Latency with mem_ready=1: lw 5, sw 4, R 4, I 4, jal 4, beq 3 cycles, each starting in FETCH.
REQ-031 All outputs other than state are combinational from state and inputs (Moore except mem_ready/zero gating).

Reset
REQ-032 rst_n=0 forces state=FETCH immediately, regardless of clk; trap=0.
REQ-033 During reset all write strobes (pc_write, ir_write, reg_write, mem_write) SHALL be 0.
REQ-034 Reset mid-instruction (any state, including mem_ready wait) abandons it; first edge after release executes FETCH.

Verification
REQ-035 op=0010011, funct3=000, mem_ready=1 -> states 0,1,8,7,0; reg_write=1 only in ALUWB; alu_control=000.
REQ-036 op=0000011, mem_ready low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, then MEMWB with result_src 01, reg_write 1.
REQ-037 op=1100011, zero=1 in BEQ -> pc_write=1, alu_control=001; zero=0 -> pc_write=0; both return to FETCH.
REQ-038 op=0110011, funct3=000, funct7b5=1 -> alu_control=001 in EXECR; funct3=111 -> 010.
REQ-039 op=1111111 -> DECODE->TRAP, trap=1, no strobes for 10 cycles; rst_n pulse -> FETCH, trap=0.
REQ-040 rst_n asserted mid-MEMWRITE with mem_ready=0 -> mem_write drops to 0 immediately, state=0.
